// File: rtl/if_id_stage_pkg.sv
// Shared definitions for the RV32I fetch/decode front end:
// opcode[6:2] classes, the NOP encoding and the bit layout of the D_out bundle.
package if_id_stage_pkg;

  localparam logic [4:0] R_TYPE = 5'b01100;
  localparam logic [4:0] IMME   = 5'b00100;
  localparam logic [4:0] LOAD   = 5'b00000;
  localparam logic [4:0] STORE  = 5'b01000;
  localparam logic [4:0] BRANCH = 5'b11000;
  localparam logic [4:0] JAL    = 5'b11011;
  localparam logic [4:0] JALR   = 5'b11001;
  localparam logic [4:0] LUI    = 5'b01101;
  localparam logic [4:0] AUIPC  = 5'b00101;

  localparam logic [31:0] NOP_INST = 32'h0000_0013;

  // D_out = {inst[30], rs2, rs1, funct3, rd, opcode[6:2]}
  localparam int DOUT_OP_LSB  = 0;
  localparam int DOUT_RD_LSB  = 5;
  localparam int DOUT_F3_LSB  = 10;
  localparam int DOUT_RS1_LSB = 13;
  localparam int DOUT_RS2_LSB = 18;
  localparam int DOUT_B30_BIT = 23;

endpackage

// File: rtl/if_id_stage_imm_gen.sv
// Immediate generator: sign-extended I/S/B/U/J immediate selected by inst[6:2].
// R-type and unknown opcodes produce zero.
module if_id_stage_imm_gen
  import if_id_stage_pkg::*;
(
  input  logic [31:0] inst,
  output logic [31:0] imm
);

  // Format select by opcode class.
  always_comb begin
    imm = '0;
    case (inst[6:2])
      IMME, LOAD, JALR: imm = {{20{inst[31]}}, inst[31:20]};
      STORE:            imm = {{20{inst[31]}}, inst[31:25], inst[11:7]};
      BRANCH:           imm = {{19{inst[31]}}, inst[31], inst[7], inst[30:25], inst[11:8], 1'b0};
      LUI, AUIPC:       imm = {inst[31:12], 12'h000};
      JAL:              imm = {{11{inst[31]}}, inst[31], inst[19:12], inst[20], inst[30:21], 1'b0};
      R_TYPE:           imm = '0;
      default:          imm = '0;
    endcase
  end

endmodule

// File: rtl/if_id_stage.sv
// RV32I fetch/decode front end: fetch PC, credit-limited instruction-memory
// requests, prefetch queue (circular buffer) and the F/D pipeline register.
// Optional macro IF_PERF_CNT_EN adds perf_issued/perf_dropped/perf_bubbles.
module if_id_stage
  import if_id_stage_pkg::*;
#(
  parameter logic [31:0] RESET_PC    = 32'h0000_0000,
  parameter int          QUEUE_DEPTH = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        stall,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  output logic        im_req,
  output logic [31:0] im_addr,
  input  logic        im_ready,
  input  logic        im_rvalid,
  input  logic [31:0] im_rdata,
  output logic        D_valid,
  output logic [31:0] D_pc,
  output logic [31:0] D_inst,
  output logic [23:0] D_out,
  output logic [31:0] D_imm
`ifdef IF_PERF_CNT_EN
  ,
  output logic [31:0] perf_issued,
  output logic [31:0] perf_dropped,
  output logic [31:0] perf_bubbles
`endif
);

  localparam int CNT_W = $clog2(QUEUE_DEPTH + 1);
  localparam int PTR_W = (QUEUE_DEPTH > 1) ? $clog2(QUEUE_DEPTH) : 1;
  localparam logic [CNT_W:0]   CREDITS   = (CNT_W + 1)'(QUEUE_DEPTH);
  localparam logic [CNT_W-1:0] FULL_CNT  = CNT_W'(QUEUE_DEPTH);
  localparam logic [PTR_W-1:0] LAST_SLOT = PTR_W'(QUEUE_DEPTH - 1);

  logic [31:0]      fetch_pc;
  logic [31:0]      rsp_pc;      // PC of the next response that will be kept
  logic [CNT_W-1:0] outstanding;
  logic [CNT_W-1:0] drop_cnt;
  logic [CNT_W-1:0] q_count;
  logic [PTR_W-1:0] q_head;
  logic [PTR_W-1:0] q_tail;
  logic [31:0]      q_inst [QUEUE_DEPTH];
  logic [31:0]      q_pc   [QUEUE_DEPTH];

  logic [CNT_W:0]   credit_used;
  logic             q_empty;
  logic             issue;
  logic             rsp_drop;
  logic             rsp_push;
  logic             q_pop;
  logic [31:0]      target_pc;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == LAST_SLOT) ? '0 : p + PTR_W'(1);
  endfunction

  // Request gating, response routing and queue pop decisions.
  always_comb begin
    credit_used = {1'b0, outstanding} + {1'b0, q_count};
    q_empty     = (q_count == '0);
    im_req      = rst && !redirect && (credit_used < CREDITS);
    im_addr     = fetch_pc;
    issue       = im_req && im_ready;
    rsp_drop    = im_rvalid && (redirect || (drop_cnt != '0));
    rsp_push    = im_rvalid && !rsp_drop;
    q_pop       = !redirect && !stall && !q_empty;
    target_pc   = {redirect_pc[31:2], 2'b00};
  end

  // Fetch PC, credit counters and queue pointers; a redirect discards all
  // queued words and marks every in-flight response for dropping.
  always_ff @(posedge clk) begin
    if (!rst) begin
      fetch_pc    <= RESET_PC;
      rsp_pc      <= RESET_PC;
      outstanding <= '0;
      drop_cnt    <= '0;
      q_head      <= '0;
      q_tail      <= '0;
      q_count     <= '0;
    end else if (redirect) begin
      fetch_pc    <= target_pc;
      rsp_pc      <= target_pc;
      outstanding <= outstanding - CNT_W'(im_rvalid);
      drop_cnt    <= outstanding - CNT_W'(im_rvalid);
      q_head      <= '0;
      q_tail      <= '0;
      q_count     <= '0;
    end else begin
      if (issue) fetch_pc <= fetch_pc + 32'd4;
      outstanding <= outstanding + CNT_W'(issue) - CNT_W'(im_rvalid);
      if (im_rvalid && (drop_cnt != '0)) drop_cnt <= drop_cnt - CNT_W'(1);
      if (rsp_push) begin
        q_tail <= ptr_inc(q_tail);
        rsp_pc <= rsp_pc + 32'd4;
      end
      if (q_pop) q_head <= ptr_inc(q_head);
      q_count <= q_count + CNT_W'(rsp_push) - CNT_W'(q_pop);
    end
  end

  // Queue storage; no reset needed since occupancy guards every read.
  always_ff @(posedge clk) begin
    if (rst && rsp_push) begin
      q_inst[q_tail] <= im_rdata;
      q_pc[q_tail]   <= rsp_pc;
    end
  end

  // A push into a full queue without a pop means the credit limit was broken.
  always_ff @(posedge clk) begin
    if (rst && !redirect) begin
      assert (!(rsp_push && !q_pop && (q_count == FULL_CNT)));
    end
  end

  // F/D register: redirect or empty queue loads a bubble; stall holds.
  always_ff @(posedge clk) begin
    if (!rst) begin
      D_valid <= 1'b0;
      D_inst  <= NOP_INST;
      D_pc    <= '0;
    end else if (redirect || (!stall && q_empty)) begin
      D_valid <= 1'b0;
      D_inst  <= NOP_INST;
    end else if (q_pop) begin
      D_valid <= 1'b1;
      D_inst  <= q_inst[q_head];
      D_pc    <= q_pc[q_head];
    end
  end

  // Decoded field bundle of the D instruction.
  always_comb begin
    D_out                          = '0;
    D_out[DOUT_OP_LSB  +: 5]       = D_inst[6:2];
    D_out[DOUT_RD_LSB  +: 5]       = D_inst[11:7];
    D_out[DOUT_F3_LSB  +: 3]       = D_inst[14:12];
    D_out[DOUT_RS1_LSB +: 5]       = D_inst[19:15];
    D_out[DOUT_RS2_LSB +: 5]       = D_inst[24:20];
    D_out[DOUT_B30_BIT]            = D_inst[30];
  end

  if_id_stage_imm_gen u_imm_gen (
    .inst (D_inst),
    .imm  (D_imm)
  );

`ifdef IF_PERF_CNT_EN
  // Event counters; they wrap naturally at 2^32.
  always_ff @(posedge clk) begin
    if (!rst) begin
      perf_issued  <= '0;
      perf_dropped <= '0;
      perf_bubbles <= '0;
    end else begin
      perf_issued  <= perf_issued + 32'(issue);
      perf_dropped <= perf_dropped + 32'(rsp_drop);
      perf_bubbles <= perf_bubbles + 32'(!stall && (redirect || q_empty));
    end
  end
`endif

endmodule
